write_buffer: RTL and testbench

WRITE_BUFFER -- requirements
Module: write_buffer

---
 rtl/wbuf_pkg.sv | 21 ++
 rtl/wbuf_fifo.sv | 80 ++++++++
 rtl/write_buffer.sv | 118 +++++++++++
 tb/tb_write_buffer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/wbuf_pkg.sv
// Shared types and defaults for the write buffer: default widths, the {addr,data}
// entry record and the drain state machine encoding.
package wbuf_pkg;

    localparam int WBUF_ADDR_W = 32;
    localparam int WBUF_DATA_W = 32;
    localparam int WBUF_DEPTH  = 4;

    // Entry record at the default widths; the RTL itself is width-parameterised.
    typedef struct packed {
        logic [WBUF_ADDR_W-1:0] addr;
        logic [WBUF_DATA_W-1:0] data;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_REQ  = 2'd1,
        WB_POP  = 2'd2
    } wbuf_state_e;

endpackage : wbuf_pkg

// File: rtl/wbuf_fifo.sv
// Circular storage, pointers and occupancy count for the write buffer.
// With WBUF_FORWARD_EN defined, the raw entries and read pointer are exported for lookup.
module wbuf_fifo
    import wbuf_pkg::*;
#(
    parameter int DEPTH  = WBUF_DEPTH,
    parameter int ADDR_W = WBUF_ADDR_W,
    parameter int DATA_W = WBUF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [ADDR_W-1:0]        head_addr,
    output logic [DATA_W-1:0]        head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
`ifdef WBUF_FORWARD_EN
    ,
    output logic [ADDR_W-1:0]        ent_addr [DEPTH],
    output logic [DATA_W-1:0]        ent_data [DEPTH],
    output logic [$clog2(DEPTH)-1:0] head_ptr
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // full is registered occupancy, so a push in the same cycle as a pop is still refused.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // NOTE: the storage array has no reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[wr_ptr] <= wr_addr;
            data_q[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

`ifdef WBUF_FORWARD_EN
    assign ent_addr = addr_q;
    assign ent_data = data_q;
    assign head_ptr = rd_ptr;
`endif

endmodule : wbuf_fifo

// File: rtl/write_buffer.sv
// Posted write buffer between a cache and backing memory: FIFO of {addr,data} drained by
// a REQ/ack FSM. Define WBUF_FORWARD_EN to enable read-miss forwarding (hit/hit_data).
module write_buffer
    import wbuf_pkg::*;
#(
    parameter int DEPTH  = WBUF_DEPTH,
    parameter int ADDR_W = WBUF_ADDR_W,
    parameter int DATA_W = WBUF_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic                   hit,
    output logic [DATA_W-1:0]      hit_data,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_data,
    input  logic                   mem_ack
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wbuf_state_e       state_q;
    wbuf_state_e       state_d;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

`ifdef WBUF_FORWARD_EN
    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  fwd_idx;
`endif

    wbuf_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr),
        .wr_addr   (addr),
        .wr_data   (data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
`ifdef WBUF_FORWARD_EN
        ,
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .head_ptr  (head_ptr)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WB_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            WB_IDLE: begin
                if (!empty) state_d = WB_REQ;
            end
            WB_REQ: begin
                mem_req = 1'b1;
                if (mem_ack) state_d = WB_POP;
            end
            WB_POP: begin
                pop     = 1'b1;
                state_d = (count > CNT_W'(1)) ? WB_REQ : WB_IDLE;
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // Head is frozen while in REQ: it only moves in POP and pushes cannot overwrite it.
    assign mem_addr = mem_req ? head_addr : '0;
    assign mem_data = mem_req ? head_data : '0;

`ifdef WBUF_FORWARD_EN
    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) && (ent_addr[fwd_idx] == rd_addr)) begin
                hit      = 1'b1;
                hit_data = ent_data[fwd_idx];
            end
        end
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

endmodule : write_buffer

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: a scoreboard queue of expected memory writes is checked
// by a separate monitor whenever the DUT's mem_req is acknowledged.
module tb_write_buffer;
    import wbuf_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                   clk;
    logic                   rst_n;
    logic                   wr;
    logic [ADDR_W-1:0]      addr;
    logic [DATA_W-1:0]      data;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic [ADDR_W-1:0]      rd_addr;
    logic                   hit;
    logic [DATA_W-1:0]      hit_data;
    logic                   mem_req;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_data;
    logic                   mem_ack;

    int n_checks = 0;
    int n_pass   = 0;

    wbuf_entry_t exp_q[$];

    write_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (wr),
        .addr     (addr),
        .data     (data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .rd_addr  (rd_addr),
        .hit      (hit),
        .hit_data (hit_data),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_ack  (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wbuf_entry_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for mem_req, hold off for gap cycles, then acknowledge for one cycle.
    task automatic serve(input int gap);
        int i = 0;
        while (!mem_req && i < 50) begin
            tick();
            i++;
        end
        check("mem_req_seen", 64'(mem_req), 64'd1);
        if (!mem_req) return;
        repeat (gap) tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    // Monitor: compare each acknowledged request against the scoreboard; check hold-stability.
    logic              prev_req = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_data = '0;
    always @(negedge clk) begin
        wbuf_entry_t e;
        if (mem_req && prev_req) begin
            check("mem_addr_stable", 64'(mem_addr), 64'(prev_addr));
            check("mem_data_stable", 64'(mem_data), 64'(prev_data));
        end
        if (mem_req && mem_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(mem_addr), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("mem_addr", 64'(mem_addr), 64'(e.addr));
                check("mem_data", 64'(mem_data), 64'(e.data));
            end
        end
        prev_req  = mem_req;
        prev_addr = mem_addr;
        prev_data = mem_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        data    = '0;
        rd_addr = '0;
        mem_ack = 1'b0;
        #2;
        check("rst_full",     64'(full),     64'd0);
        check("rst_empty",    64'(empty),    64'd1);
        check("rst_count",    64'(count),    64'd0);
        check("rst_mem_req",  64'(mem_req),  64'd0);
        check("rst_hit",      64'(hit),      64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_data", 64'(mem_data), 64'd0);
        check("rst_hit_data", 64'(hit_data), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Two pushes, each acknowledged three cycles into its request.
        wr = 1'b1; addr = 32'h0; data = 32'h1; expect_write(32'h0, 32'h1);
        tick();
        addr = 32'h1; data = 32'h3; expect_write(32'h1, 32'h3);
        tick();
        wr = 1'b0;
        check("t1_count2", 64'(count), 64'd2);
        check("t1_req",    64'(mem_req), 64'd1);
        serve(2);
        check("t1_pop_count_held", 64'(count), 64'd2);
        check("t1_pop_no_req",     64'(mem_req), 64'd0);
        tick();
        check("t1_count1",  64'(count),   64'd1);
        check("t1_req2",    64'(mem_req), 64'd1);
        serve(2);
        tick();
        check("t1_empty",   64'(empty),   64'd1);
        check("t1_count0",  64'(count),   64'd0);
        check("t1_idle",    64'(mem_req), 64'd0);

        // Five pushes with no ack: fourth fills the buffer, fifth is dropped.
        for (int i = 0; i < 5; i++) begin
            wr   = 1'b1;
            addr = 32'h10 + 32'(i);
            data = 32'h20 + 32'(i);
            if (i < 4) expect_write(32'h10 + 32'(i), 32'h20 + 32'(i));
            tick();
            if (i == 3) begin
                check("t2_full_after4",  64'(full),  64'd1);
                check("t2_count_after4", 64'(count), 64'd4);
            end
        end
        wr = 1'b0;
        check("t2_count_after5", 64'(count), 64'd4);
        check("t2_full_after5",  64'(full),  64'd1);
        check("t2_head_addr",    64'(mem_addr), 64'h10);

        // Full buffer: push alongside mem_ack and again during POP are both refused.
        wr = 1'b1; addr = 32'h99; data = 32'h99; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t3_pop_full", 64'(full),  64'd1);
        check("t3_pop_cnt",  64'(count), 64'd4);
        tick();
        wr = 1'b0;
        check("t3_count3", 64'(count), 64'd3);
        check("t3_not_full", 64'(full), 64'd0);
        serve(1);
        serve(1);
        serve(1);
        tick();
        check("t3_empty", 64'(empty), 64'd1);
        check("t3_sb_drained", 64'(exp_q.size()), 64'd0);

        // Duplicate addresses, then forwarding lookup while the head is in REQ.
        wr = 1'b1; addr = 32'h8; data = 32'hA; expect_write(32'h8, 32'hA);
        tick();
        data = 32'hB; expect_write(32'h8, 32'hB);
        tick();
        wr = 1'b0;
        check("t4_count2", 64'(count),   64'd2);
        check("t4_req",    64'(mem_req), 64'd1);
        rd_addr = 32'h8;
        #1;
`ifdef WBUF_FORWARD_EN
        check("t4_hit",      64'(hit),      64'd1);
        check("t4_hit_data", 64'(hit_data), 64'hB);
        rd_addr = 32'hC;
        #1;
        check("t4_miss", 64'(hit), 64'd0);
`else
        check("t4_hit_tied",      64'(hit),      64'd0);
        check("t4_hit_data_tied", 64'(hit_data), 64'd0);
`endif

        // Reset mid-request: everything clears at once and nothing is requested afterwards.
        rst_n = 1'b0;
        #1;
        check("t5_req_clr",   64'(mem_req),  64'd0);
        check("t5_count_clr", 64'(count),    64'd0);
        check("t5_empty",     64'(empty),    64'd1);
        check("t5_addr_clr",  64'(mem_addr), 64'd0);
        check("t5_hit_clr",   64'(hit),      64'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_no_req", 64'(mem_req), 64'd0);
        end
        check("t5_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_write_buffer
